logic_eval_sweep: RTL and testbench

LOGIC_EVAL_SWEEP -- requirements
Module: logic_eval_sweep

---
 rtl/logic_eval_sweep.sv | 109 ++++++++++
 tb/tb_logic_eval_sweep.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_eval_sweep.sv
// Bitwise logic evaluator with a valid/ready result register and a truth-table
// sweep mode that walks the selected function through all four (a,b) bit combinations.
module logic_eval_sweep #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [1:0]       out_idx,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t     state;
   logic [2:0] sweep_op;
   logic [1:0] k;
   logic       last_loaded;

   logic out_free;
   logic in_xfer;
   logic sweep_load;

   function automatic logic [WIDTH-1:0] eval_op(input logic [2:0] f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      r = '0;
      case (f)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = ~(x & y);
         3'd3: r = ~(x | y);
         3'd4: r = x ^ y;
         3'd5: r = ~(x ^ y);
         3'd6: r = x & ~y;
         3'd7: r = ~x & y;
         default: r = '0;
      endcase
      return r;
   endfunction

   // The result register can take new data when empty or being drained this cycle.
   assign out_free   = !out_valid || out_ready;
   assign in_ready   = (state == IDLE) && !sweep_start && out_free;
   assign in_xfer    = in_valid && in_ready;
   assign sweep_load = (state == SWEEP) && !last_loaded && out_free;
   assign sweep_busy = (state != IDLE);
   assign sweep_done = (state == DONE);

   // last_loaded marks that step 3 is in the register, so k can stay at 3 without wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sweep_op    <= '0;
         k           <= '0;
         last_loaded <= 1'b0;
         s           <= '0;
         out_idx     <= '0;
         out_valid   <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  s         <= eval_op(op, a, b);
                  out_idx   <= 2'd0;
                  out_valid <= 1'b1;
               end else if (sweep_start && out_free) begin
                  state       <= SWEEP;
                  sweep_op    <= op;
                  k           <= 2'd0;
                  last_loaded <= 1'b0;
               end
            end
            SWEEP: begin
               if (sweep_load) begin
                  s         <= eval_op(sweep_op, {WIDTH{k[1]}}, {WIDTH{k[0]}});
                  out_idx   <= k;
                  out_valid <= 1'b1;
                  if (k == 2'd3)
                     last_loaded <= 1'b1;
                  else
                     k <= k + 2'd1;
               end else if (last_loaded && out_valid && out_ready) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state       <= IDLE;
               k           <= 2'd0;
               last_loaded <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_logic_eval_sweep.sv
// Self-checking bench for logic_eval_sweep: table-driven requests, sweep sequences,
// back-pressure and mid-sweep reset, with a scoreboard queue of expected results.
module tb_logic_eval_sweep;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic [1:0]       out_idx;
   logic             sweep_start;
   logic             sweep_busy;
   logic             sweep_done;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_s;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic [1:0]       idx;
   } exp_t;

   vec_t vecs[8];
   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   done_count = 0;
   logic prev_done  = 1'b0;

   logic_eval_sweep #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .s          (s),
      .out_idx    (out_idx),
      .sweep_start(sweep_start),
      .sweep_busy (sweep_busy),
      .sweep_done (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExp(input logic [WIDTH-1:0] es, input logic [1:0] ei);
      exp_t e;
      e.s   = es;
      e.idx = ei;
      sb.push_back(e);
   endtask

   // Drives one request and holds it until accepted; leaves in_valid high for back-to-back use.
   task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] va,
                                input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] es);
      int n;
      n        = 0;
      in_valid = 1'b1;
      op       = o;
      a        = va;
      b        = vb;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 50) begin
            checkOutput("accept_timeout", 0, 1);
            return;
         end
      end
      pushExp(es, 2'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("drain_timeout", sb.size(), 0);
   endtask

   task automatic waitDoneCount(input int target);
      int n;
      n = 0;
      while (done_count < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("sweep_done_count", done_count, target);
   endtask

   // Scoreboard: every output transfer pops and compares one expected result.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_done = 1'b0;
      end else begin
         if (sweep_done) begin
            checkOutput("sweep_done_width", prev_done, 0);
            done_count++;
         end
         prev_done = sweep_done;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_result: got s=%0h idx=%0d, expected none", s, out_idx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checkOutput("s", s, e.s);
               checkOutput("out_idx", out_idx, e.idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   cyc;
      int   done_before;
      logic prev_xfer3;

      vecs[0] = '{3'd0, 4'b1100, 4'b1010, 4'b1000};
      vecs[1] = '{3'd1, 4'b1100, 4'b1010, 4'b1110};
      vecs[2] = '{3'd2, 4'b1100, 4'b1010, 4'b0111};
      vecs[3] = '{3'd3, 4'b1100, 4'b1010, 4'b0001};
      vecs[4] = '{3'd4, 4'b1100, 4'b1010, 4'b0110};
      vecs[5] = '{3'd5, 4'b1100, 4'b1010, 4'b1001};
      vecs[6] = '{3'd6, 4'b1100, 4'b1010, 4'b0100};
      vecs[7] = '{3'd7, 4'b1100, 4'b1010, 4'b0010};

      rst_n       = 1'b0;
      in_valid    = 1'b0;
      op          = '0;
      a           = '0;
      b           = '0;
      out_ready   = 1'b1;
      sweep_start = 1'b0;
      #12;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_s", s, 0);
      checkOutput("rst_out_idx", out_idx, 0);
      checkOutput("rst_sweep_busy", sweep_busy, 0);
      checkOutput("rst_sweep_done", sweep_done, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("post_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      $display("[TB] single request op=6");
      applyStimulus(3'd6, 4'b1100, 4'b1010, 4'b0100);
      in_valid = 1'b0;
      checkOutput("lat_out_valid", out_valid, 1);
      checkOutput("lat_s", s, 4'b0100);
      checkOutput("lat_out_idx", out_idx, 0);
      waitDrain();

      $display("[TB] back-to-back op sweep 0..7");
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++)
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_s);
      in_valid = 1'b0;
      waitDrain();

      $display("[TB] sweep op=6 free-running");
      @(posedge clk);
      #1;
      done_before = done_count;
      sweep_start = 1'b1;
      op          = 3'd6;
      pushExp(4'b0000, 2'd0);
      pushExp(4'b0000, 2'd1);
      pushExp(4'b1111, 2'd2);
      pushExp(4'b0000, 2'd3);
      @(negedge clk);
      checkOutput("in_ready_at_start", in_ready, 0);
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      cyc         = 0;
      prev_xfer3  = 1'b0;
      while (cyc < 20) begin
         @(negedge clk);
         cyc++;
         checkOutput("in_ready_busy", in_ready, 0);
         if (sweep_done) break;
         prev_xfer3 = out_valid && out_ready && (out_idx == 2'd3);
      end
      checkOutput("sweep_cycles", cyc, 6);
      checkOutput("done_after_last_xfer", prev_xfer3, 1);
      @(negedge clk);
      checkOutput("done_one_cycle", sweep_done, 0);
      checkOutput("idle_not_busy", sweep_busy, 0);
      checkOutput("one_done_pulse", done_count, done_before + 1);

      $display("[TB] sweep op=4 with back-pressure at step 1");
      @(posedge clk);
      #1;
      done_before = done_count;
      sweep_start = 1'b1;
      op          = 3'd4;
      pushExp(4'b0000, 2'd0);
      pushExp(4'b1111, 2'd1);
      pushExp(4'b1111, 2'd2);
      pushExp(4'b0000, 2'd3);
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("stall_s", s, 4'b1111);
         checkOutput("stall_idx", out_idx, 1);
         checkOutput("stall_valid", out_valid, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      waitDoneCount(done_before + 1);
      waitDrain();

      $display("[TB] sweep_start with in_valid");
      @(posedge clk);
      #1;
      done_before = done_count;
      sweep_start = 1'b1;
      in_valid    = 1'b1;
      op          = 3'd6;
      a           = 4'b1100;
      b           = 4'b1010;
      @(negedge clk);
      checkOutput("collide_in_ready", in_ready, 0);
      pushExp(4'b0000, 2'd0);
      pushExp(4'b0000, 2'd1);
      pushExp(4'b1111, 2'd2);
      pushExp(4'b0000, 2'd3);
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      applyStimulus(3'd6, 4'b1100, 4'b1010, 4'b0100);
      in_valid = 1'b0;
      checkOutput("accepted_after_done", done_count, done_before + 1);
      waitDrain();

      $display("[TB] reset at sweep step 2");
      @(posedge clk);
      #1;
      done_before = done_count;
      sweep_start = 1'b1;
      op          = 3'd1;
      pushExp(4'b0000, 2'd0);
      pushExp(4'b1111, 2'd1);
      pushExp(4'b1111, 2'd2);
      pushExp(4'b1111, 2'd3);
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre_reset_idx", out_idx, 2);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_s", s, 0);
      checkOutput("arst_out_valid", out_valid, 0);
      checkOutput("arst_out_idx", out_idx, 0);
      checkOutput("arst_busy", sweep_busy, 0);
      checkOutput("arst_done", sweep_done, 0);
      checkOutput("arst_in_ready", in_ready, 1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("rel_in_ready", in_ready, 1);
      applyStimulus(3'd0, 4'b1111, 4'b0101, 4'b0101);
      in_valid = 1'b0;
      waitDrain();
      checkOutput("no_done_after_abort", done_count, done_before);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
